// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS fetch stage.
// Runs a BOOT/RUN/HALT sequencer and counts every fetched instruction that advances.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_0800,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        pc_r;
    logic               fetch_valid_r;
    logic               halted_r;
    logic               fault_r;
    logic [CNT_W-1:0]   fetch_count_r;

    logic [31:0]        pc_plus4_s;
    logic [31:0]        branch_target_s;
    logic [31:0]        jump_target_s;
    logic [31:0]        next_pc_s;
    logic               self_jump_s;
    logic               out_of_range_s;
    logic [CNT_W-1:0]   count_inc_s;

    // Candidate targets, jump-over-branch selection, halt/fault detection.
    always_comb begin
        pc_plus4_s      = pc_r + 32'd4;
        branch_target_s = pc_plus4_s + (branch_offset << 2);
        jump_target_s   = {pc_plus4_s[31:28], jump_index, 2'b00};
        next_pc_s       = pc_plus4_s;
        if (jump) begin
            next_pc_s = jump_target_s;
        end else if (branch_taken) begin
            next_pc_s = branch_target_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
        self_jump_s    = jump && (jump_target_s == pc_r);
        out_of_range_s = (next_pc_s >= PC_LIMIT);
        // Counter sticks at all-ones rather than wrapping to zero.
        if (fetch_count_r != {CNT_W{1'b1}}) begin
            count_inc_s = fetch_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_inc_s = fetch_count_r;
        end
    end

    // Sequencer and PC/status registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            fetch_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
            fetch_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    pc_r          <= RESET_PC;
                    fetch_valid_r <= 1'b1;
                    halted_r      <= 1'b0;
                    fault_r       <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state_r       <= HALT;
                        fetch_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                        fault_r       <= 1'b0;
                    end else if (stall) begin
                        state_r <= RUN;
                    end else begin
                        fetch_count_r <= count_inc_s;
                        if (self_jump_s) begin
                            state_r       <= HALT;
                            fetch_valid_r <= 1'b0;
                            halted_r      <= 1'b1;
                            fault_r       <= 1'b0;
                        end else if (out_of_range_s) begin
                            // Keep the offending address visible for debug.
                            state_r       <= HALT;
                            pc_r          <= next_pc_s;
                            fetch_valid_r <= 1'b0;
                            halted_r      <= 1'b1;
                            fault_r       <= 1'b1;
                        end else begin
                            pc_r <= next_pc_s;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_r       <= BOOT;
                        pc_r          <= RESET_PC;
                        fetch_valid_r <= 1'b0;
                        halted_r      <= 1'b0;
                        fault_r       <= 1'b0;
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r       <= BOOT;
                    pc_r          <= RESET_PC;
                    fetch_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                    fault_r       <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_valid = fetch_valid_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: sequential fetch, branch, jump,
// stall, halt paths, range fault, resume and reset from RUN and HALT.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
        .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0;
        jump = 1'b0; jump_index = 26'd0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic jump_to(input logic [25:0] idx);
        idle(); jump = 1'b1; jump_index = idx; step(); idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; step(); step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b%b exp=00", halted, fault); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_sequential();
        idle();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL boot pc=%h fv=%b exp 0/0", pc, fetch_valid); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL boot_pc4 got=%h exp=4", pc_plus4); end
        step();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1 || fetch_count !== 32'd0) begin errors++; $display("FAIL run0 pc=%h fv=%b cnt=%0d exp 0/1/0", pc, fetch_valid, fetch_count); end
        step();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got=%h exp=4", pc); end
        step();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8 got=%h exp=8", pc); end
        step();
        checks++; if (pc !== 32'hC || fetch_count !== 32'd3) begin errors++; $display("FAIL seq_pcC pc=%h cnt=%0d exp C/3", pc, fetch_count); end
    endtask

    task automatic test_branch();
        jump_to(26'h8);
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_setup got=%h exp=20", pc); end
        branch_taken = 1'b1; branch_offset = 32'h0000_0009; step(); idle();
        checks++; if (pc !== 32'h48 || fetch_count !== 32'd5) begin errors++; $display("FAIL br_fwd pc=%h cnt=%0d exp 48/5", pc, fetch_count); end
        jump_to(26'h8);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE; step(); idle();
        checks++; if (pc !== 32'h1C || fetch_count !== 32'd7) begin errors++; $display("FAIL br_back pc=%h cnt=%0d exp 1C/7", pc, fetch_count); end
    endtask

    task automatic test_jump_stall();
        jump_to(26'h11);
        jump = 1'b1; jump_index = 26'h0E; branch_taken = 1'b1; branch_offset = 32'h10; step();
        checks++; if (pc !== 32'h38 || fetch_count !== 32'd9) begin errors++; $display("FAIL jmp_wins pc=%h cnt=%0d exp 38/9", pc, fetch_count); end
        branch_taken = 1'b0; jump = 1'b1; jump_index = 26'h20; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h38 || fetch_count !== 32'd9) begin errors++; $display("FAIL stall%0d pc=%h cnt=%0d exp 38/9", i, pc, fetch_count); end
        end
        idle();
    endtask

    task automatic test_self_jump();
        jump_to(26'h1F);
        jump = 1'b1; jump_index = 26'h1F; step(); idle();
        checks++; if (halted !== 1'b1 || pc !== 32'h7C || fault !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL selfjmp h=%b pc=%h f=%b fv=%b exp 1/7C/0/0", halted, pc, fault, fetch_valid); end
        checks++; if (fetch_count !== 32'd11) begin errors++; $display("FAIL selfjmp_cnt got=%0d exp=11", fetch_count); end
        jump = 1'b1; jump_index = 26'h10; branch_taken = 1'b1; halt_req = 1'b1; step(); idle();
        checks++; if (halted !== 1'b1 || pc !== 32'h7C || fetch_count !== 32'd11) begin errors++; $display("FAIL halt_ignore pc=%h h=%b cnt=%0d exp 7C/1/11", pc, halted, fetch_count); end
        resume = 1'b1; step(); idle();
        checks++; if (pc !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL resume_boot pc=%h h=%b fv=%b exp 0/0/0", pc, halted, fetch_valid); end
        step();
        checks++; if (fetch_valid !== 1'b1 || pc !== 32'h0 || fetch_count !== 32'd11) begin errors++; $display("FAIL resume_run fv=%b pc=%h cnt=%0d exp 1/0/11", fetch_valid, pc, fetch_count); end
    endtask

    task automatic test_range_fault();
        jump_to(26'h1FF);
        checks++; if (pc !== 32'h7FC || halted !== 1'b0) begin errors++; $display("FAIL rng_setup pc=%h h=%b exp 7FC/0", pc, halted); end
        step();
        checks++; if (pc !== 32'h800 || halted !== 1'b1 || fault !== 1'b1) begin errors++; $display("FAIL rng_fault pc=%h h=%b f=%b exp 800/1/1", pc, halted, fault); end
        checks++; if (fetch_count !== 32'd13) begin errors++; $display("FAIL rng_cnt got=%0d exp=13", fetch_count); end
        resume = 1'b1; step(); idle();
        checks++; if (pc !== 32'h0 || fault !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rng_resume pc=%h f=%b h=%b exp 0/0/0", pc, fault, halted); end
        step();
    endtask

    task automatic test_halt_req();
        resume = 1'b1; step(); idle();
        checks++; if (pc !== 32'h4 || halted !== 1'b0) begin errors++; $display("FAIL resume_in_run pc=%h h=%b exp 4/0", pc, halted); end
        halt_req = 1'b1; jump = 1'b1; jump_index = 26'h40; step(); idle();
        checks++; if (halted !== 1'b1 || pc !== 32'h4 || fault !== 1'b0 || fetch_count !== 32'd14) begin errors++; $display("FAIL halt_req h=%b pc=%h f=%b cnt=%0d exp 1/4/0/14", halted, pc, fault, fetch_count); end
        resume = 1'b1; step(); idle(); step();
    endtask

    task automatic test_reset_mid();
        jump_to(26'h0C);
        checks++; if (pc !== 32'h30 || fetch_valid !== 1'b1) begin errors++; $display("FAIL rst_setup pc=%h fv=%b exp 30/1", pc, fetch_valid); end
        jump = 1'b1; jump_index = 26'h20; reset = 1'b1; step(); idle();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL rst_run pc=%h fv=%b cnt=%0d h=%b exp 0/0/0/0", pc, fetch_valid, fetch_count, halted); end
        step();
        jump_to(26'h0);
        checks++; if (halted !== 1'b1 || fetch_count !== 32'd1) begin errors++; $display("FAIL rst_halt_setup h=%b cnt=%0d exp 1/1", halted, fetch_count); end
        reset = 1'b1; step(); idle();
        checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL rst_halt pc=%h fv=%b cnt=%0d h=%b exp 0/0/0/0", pc, fetch_valid, fetch_count, halted); end
        step();
        checks++; if (fetch_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL rst_rerun fv=%b pc=%h exp 1/0", fetch_valid, pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_stall();
        test_self_jump();
        test_range_fault();
        test_halt_req();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the instruction memory in the single-cycle MIPS CPU.
- Owns the program counter and drives the byte address `pc` into instruction memory, which indexes words with pc[10:2].
- Selects the next PC each cycle from sequential, branch or jump sources.
- Supports stall, halt-on-self-jump, halt request, out-of-range fault and restart, and counts fetched instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on resume.
- PC_LIMIT, 32'h0000_0800, exclusive upper bound of legal fetch addresses; matches the 2 KB instruction memory window.
- CNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- branch_taken  in  1  beq resolved taken for the current instruction.
- branch_offset  in  32  sign-extended 16-bit immediate, in words.
- jump  in  1  current instruction is j.
- jump_index  in  26  instruction[25:0].
- halt_req  in  1  external halt request.
- resume  in  1  restart from HALT.
- pc  out  32  current fetch address, to instruction memory.
- pc_plus4  out  32  pc+4, combinational, for branch-target and link use.
- fetch_valid  out  1  high when pc addresses a valid instruction this cycle.
- halted  out  1  FSM is in HALT.
- fault  out  1  halt was caused by an out-of-range PC.
- fetch_count  out  CNT_W  number of instructions fetched and advanced.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk, and overrides every other input.
- Reset values: pc=RESET_PC, FSM=BOOT, fetch_valid=0, halted=0, fault=0, fetch_count=0.
- FSM states:
  - BOOT: one cycle. pc=RESET_PC, fetch_valid=0. Always goes to RUN next cycle, unless reset.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1, pc holds.
- Target arithmetic, 32-bit and modulo 2^32 (wrap is not detected except via the PC_LIMIT check):
  - branch_target = pc_plus4 + (branch_offset << 2).
  - jump_target = {pc_plus4[31:28], jump_index, 2'b00}.
  - pc[1:0] is always 00 by construction.
- Next-PC priority in RUN, highest first:
  1. halt_req → HALT, pc holds, fault=0.
  2. stall → pc holds, no count.
  3. jump → jump_target.
  4. branch_taken → branch_target.
  5. Otherwise pc_plus4.
- Self-jump: jump=1 with jump_target==pc → HALT, pc holds, fault=0. This is the program-end idiom. The jump is counted.
- Range fault: a selected next PC >= PC_LIMIT → HALT with pc loaded to the offending value and fault=1. The instruction is counted.
- If jump and branch_taken are both high, jump wins.
- In HALT, stall, jump, branch_taken and halt_req are ignored. resume=1 → next cycle BOOT, with pc=RESET_PC and fault=0. fetch_count is retained.
- resume in BOOT or RUN is ignored.
- fetch_count increments by 1 on each RUN cycle that is not stalled and not halted by halt_req. It saturates at all-ones.
- All outputs except pc_plus4 are registered. Latency from a control input to the new pc is one clock edge.

Test Plan:
- Sequential run: reset for 2 cycles, then release with all controls low → pc is 0 in BOOT, then 0,4,8,C; fetch_valid 0 then 1; fetch_count=3 after pc reaches C.
- Branch: at pc=0x20, branch_taken=1, branch_offset=0x0000_0009 → next pc=0x48. With branch_offset=0xFFFF_FFFE → next pc=0x1C.
- Jump vs branch and stall: at pc=0x44, jump=1, jump_index=0x0E, branch_taken=1 → pc=0x38. Then stall=1 with jump=1 for 3 cycles → pc stays 0x38 and fetch_count is unchanged.
- Self-jump halt: at pc=0x7C, jump=1, jump_index=0x1F → halted=1, pc=0x7C, fault=0, fetch_valid=0. Then resume=1 → BOOT at pc=0, then RUN.
- Range fault: at pc=0x7FC with no control active → pc=0x800, halted=1, fault=1. Then resume → fault=0, pc=0.
- Reset mid-operation: at pc=0x30 in RUN with jump=1, assert reset → next edge pc=0, BOOT, fetch_count=0, halted=0. Repeat while in HALT with the same result.
